// File: rtl/wash_phase_timer.sv
// Wash-phase interval timer: times fill/soap/rinse/drain/spin intervals in prescaled ticks.
// Optional: WASH_TIMER_DOOR_PAUSE_EN freezes counting in RUN while the door is open.
module wash_phase_timer #(
    parameter int unsigned PRESCALE    = 1000,
    parameter int unsigned FILL_TICKS  = 20,
    parameter int unsigned SOAP_TICKS  = 60,
    parameter int unsigned RINSE_TICKS = 40,
    parameter int unsigned DRAIN_TICKS = 15,
    parameter int unsigned SPIN_TICKS  = 30
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        fill_value_on,
    input  logic        motor_on,
    input  logic        soap_wash,
    input  logic        water_wash,
    input  logic        drain_value_on,
    input  logic        spin_req,
    input  logic        door_close,
    output logic        filled,
    output logic        cycle_timeout,
    output logic        drained,
    output logic        spin_timeout,
    output logic        busy,
    output logic        fault,
    output logic [15:0] remaining
);
    localparam int PW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
    localparam logic [PW-1:0] PRE_LAST = PW'(PRESCALE - 1);

    typedef enum logic [1:0] {IDLE, RUN, HOLD, FAULT} state_t;
    typedef enum logic [2:0] {K_FILL, K_SOAP, K_RINSE, K_DRAIN, K_SPIN} kind_t;

    state_t        state;
    kind_t         kind;
    kind_t         new_kind;
    logic [PW-1:0] presc;
    logic          pend;
    logic [4:0]    req;
    logic          conflict;
    logic          tick_en;

    function automatic logic [15:0] load_ticks(input kind_t k);
        int unsigned t;
        case (k)
            K_FILL:  t = FILL_TICKS;
            K_SOAP:  t = SOAP_TICKS;
            K_RINSE: t = RINSE_TICKS;
            K_DRAIN: t = DRAIN_TICKS;
            default: t = SPIN_TICKS;
        endcase
        return (t == 0) ? 16'd1 : 16'(t);
    endfunction

    // Bit index of req matches the kind_t encoding.
    assign req = {spin_req, drain_value_on, motor_on & water_wash,
                  motor_on & soap_wash, fill_value_on};
    assign conflict = ($countones(req) > 1) || (motor_on && (soap_wash == water_wash));

    always_comb begin
        new_kind = K_FILL;
        for (int i = 4; i >= 0; i--)
            if (req[i]) new_kind = kind_t'(3'(i));
    end

`ifdef WASH_TIMER_DOOR_PAUSE_EN
    assign tick_en = door_close;
`else
    logic door_unused;
    assign door_unused = door_close;
    assign tick_en = 1'b1;
`endif

    always_ff @(posedge clk) begin
        if (!reset) begin
            state         <= IDLE;
            kind          <= K_FILL;
            presc         <= '0;
            remaining     <= '0;
            pend          <= 1'b0;
            filled        <= 1'b0;
            cycle_timeout <= 1'b0;
            drained       <= 1'b0;
            spin_timeout  <= 1'b0;
            busy          <= 1'b0;
            fault         <= 1'b0;
        end else begin
            filled        <= 1'b0;
            cycle_timeout <= 1'b0;
            drained       <= 1'b0;
            spin_timeout  <= 1'b0;
            pend          <= 1'b0;
            // Expiry pulse lands one cycle after remaining reaches zero.
            if (pend) begin
                case (kind)
                    K_FILL:          filled        <= 1'b1;
                    K_SOAP, K_RINSE: cycle_timeout <= 1'b1;
                    K_DRAIN:         drained       <= 1'b1;
                    default:         spin_timeout  <= 1'b1;
                endcase
            end
            case (state)
                IDLE: begin
                    remaining <= '0;
                    presc     <= '0;
                    if (conflict) begin
                        state <= FAULT;
                        fault <= 1'b1;
                    end else if (req != '0) begin
                        kind      <= new_kind;
                        remaining <= load_ticks(new_kind);
                        state     <= RUN;
                        busy      <= 1'b1;
                    end
                end
                RUN: begin
                    if (conflict) begin
                        state <= FAULT;
                        fault <= 1'b1;
                        busy  <= 1'b0;
                    end else if (!req[kind]) begin
                        state     <= IDLE;
                        busy      <= 1'b0;
                        remaining <= '0;
                        presc     <= '0;
                    end else if (tick_en) begin
                        if (presc == PRE_LAST) begin
                            presc     <= '0;
                            remaining <= remaining - 16'd1;
                            if (remaining == 16'd1) begin
                                state <= HOLD;
                                busy  <= 1'b0;
                                pend  <= 1'b1;
                            end
                        end else begin
                            presc <= presc + 1'b1;
                        end
                    end
                end
                HOLD: begin
                    if (!req[kind]) state <= IDLE;
                end
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_wash_phase_timer.sv
// Directed + randomized bench for wash_phase_timer against a tick-arithmetic reference model.
module tb_wash_phase_timer;
    localparam int P   = 2;
    localparam int TF  = 3;
    localparam int TS  = 5;
    localparam int TR  = 4;
    localparam int TD  = 3;
    localparam int TSP = 6;
`ifdef WASH_TIMER_DOOR_PAUSE_EN
    localparam int PAUSE = 5;
`else
    localparam int PAUSE = 0;
`endif

    logic clk = 1'b0;
    logic reset = 1'b0;
    logic fill_value_on = 1'b0, motor_on = 1'b0, soap_wash = 1'b0, water_wash = 1'b0;
    logic drain_value_on = 1'b0, spin_req = 1'b0, door_close = 1'b1;
    logic filled, cycle_timeout, drained, spin_timeout, busy, fault;
    logic [15:0] remaining;

    int total = 0;
    int passed = 0;
    int fails = 0;
    int tick_tab [5] = '{TF, TS, TR, TD, TSP};

    wash_phase_timer #(
        .PRESCALE(P), .FILL_TICKS(TF), .SOAP_TICKS(TS), .RINSE_TICKS(TR),
        .DRAIN_TICKS(TD), .SPIN_TICKS(TSP)
    ) dut (
        .clk(clk), .reset(reset), .fill_value_on(fill_value_on), .motor_on(motor_on),
        .soap_wash(soap_wash), .water_wash(water_wash), .drain_value_on(drain_value_on),
        .spin_req(spin_req), .door_close(door_close), .filled(filled),
        .cycle_timeout(cycle_timeout), .drained(drained), .spin_timeout(spin_timeout),
        .busy(busy), .fault(fault), .remaining(remaining)
    );

    always #5 clk = ~clk;

    // Pulse vector order: {filled, cycle_timeout, drained, spin_timeout}
    function automatic logic [3:0] pulse_of(input int k);
        case (k)
            0:       return 4'b1000;
            1, 2:    return 4'b0100;
            3:       return 4'b0010;
            default: return 4'b0001;
        endcase
    endfunction

    task automatic drive_kind(input int k, input logic on);
        case (k)
            0: fill_value_on = on;
            1: begin motor_on = on; soap_wash = on; end
            2: begin motor_on = on; water_wash = on; end
            3: drain_value_on = on;
            default: spin_req = on;
        endcase
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic busy_e, input logic fault_e,
                       input logic [3:0] pul_e, input logic [15:0] rem_e);
        logic [21:0] obs, expv;
        obs  = {busy, fault, filled, cycle_timeout, drained, spin_timeout, remaining};
        expv = {busy_e, fault_e, pul_e, rem_e};
        total++;
        assert (obs === expv) passed++;
        else begin
            fails++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, expv);
        end
    endtask

    task automatic chk_bit(input string tag, input logic obs, input logic expv);
        total++;
        assert (obs === expv) passed++;
        else begin
            fails++;
            $error("FAIL %s observed=%b expected=%b", tag, obs, expv);
        end
    endtask

    // Request of kind k held for h sampling edges (edge 0 = IDLE accept edge).
    task automatic run_txn(input int k, input int h);
        int t, n, last;
        logic b;
        logic [3:0] pl;
        logic [15:0] r;
        t = tick_tab[k];
        n = t * P;
        last = ((h > n + 1) ? h : n + 1) + 2;
        drive_kind(k, 1'b1);
        for (int i = 0; i <= last; i++) begin
            step();
            b = 1'b0; pl = 4'b0000; r = 16'd0;
            if (h <= n) begin
                if (i < h) begin b = 1'b1; r = 16'(t - i / P); end
            end else begin
                if (i < n) begin b = 1'b1; r = 16'(t - i / P); end
                else if (i == n + 1) pl = pulse_of(k);
            end
            chk($sformatf("txn k%0d h%0d i%0d", k, h, i), b, 1'b0, pl, r);
            if (i == h - 1) drive_kind(k, 1'b0);
        end
    endtask

    initial begin
        int k, h;
        reset = 1'b0;
        step(); step();
        chk("reset", 1'b0, 1'b0, 4'b0, 16'd0);
        reset = 1'b1;
        step();
        chk("idle", 1'b0, 1'b0, 4'b0, 16'd0);

        run_txn(0, 10);          // fill, pulse 7 cycles after accept, hold then drop
        run_txn(2, 12);          // rinse 4 ticks, pulse at 9
        run_txn(3, 3);           // drain aborted mid-run
        run_txn(4, 13);          // spin dropped exactly on pulse cycle
        for (int j = 0; j < 12; j++) begin
            k = int'($urandom_range(0, 4));
            h = int'($urandom_range(1, tick_tab[k] * P + 4));
            run_txn(k, h);
        end

        // Conflict from IDLE: fault is sticky until reset.
        fill_value_on = 1'b1; drain_value_on = 1'b1;
        step();
        chk("fault_idle", 1'b0, 1'b1, 4'b0, 16'd0);
        fill_value_on = 1'b0; drain_value_on = 1'b0;
        for (int j = 0; j < 3; j++) begin
            step();
            chk("fault_sticky", 1'b0, 1'b1, 4'b0, 16'd0);
        end
        reset = 1'b0;
        step();
        chk("fault_reset", 1'b0, 1'b0, 4'b0, 16'd0);
        reset = 1'b1;

        // Mid-run conflict: motor_on with neither qualifier freezes remaining.
        drive_kind(1, 1'b1);
        for (int i = 0; i < 5; i++) begin
            step();
            chk("soap_run", 1'b1, 1'b0, 4'b0, 16'(TS - i / P));
        end
        soap_wash = 1'b0;
        step();
        chk("fault_run", 1'b0, 1'b1, 4'b0, 16'(TS - 4 / P));
        motor_on = 1'b0;
        for (int j = 0; j < TS * P; j++) begin
            step();
            chk("fault_frozen", 1'b0, 1'b1, 4'b0, 16'(TS - 4 / P));
        end
        reset = 1'b0;
        step();
        reset = 1'b1;

        // Reset mid-spin: no expiry pulse ever.
        drive_kind(4, 1'b1);
        for (int i = 0; i < 4; i++) begin
            step();
            chk("spin_run", 1'b1, 1'b0, 4'b0, 16'(TSP - i / P));
        end
        reset = 1'b0; spin_req = 1'b0;
        step();
        chk("spin_reset", 1'b0, 1'b0, 4'b0, 16'd0);
        reset = 1'b1;
        for (int j = 0; j < TSP * P + 3; j++) begin
            step();
            chk("spin_quiet", 1'b0, 1'b0, 4'b0, 16'd0);
        end

        // Door open for 5 edges mid-fill; pause only when the feature is built in.
        drive_kind(0, 1'b1);
        for (int i = 0; i <= TF * P + 1 + 5 + 2; i++) begin
            step();
            chk_bit($sformatf("door_filled i%0d", i), filled, (i == TF * P + 1 + PAUSE));
            chk_bit($sformatf("door_busy i%0d", i), busy, (i < TF * P + PAUSE));
            if (i == 1) door_close = 1'b0;
            if (i == 6) door_close = 1'b1;
        end
        drive_kind(0, 1'b0);
        step(); step();
        chk("final_idle", 1'b0, 1'b0, 4'b0, 16'd0);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
